// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle between the command master and a register slave
interface axil_cmd_master_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite register master (optional slow-slave flag: AXIL_MASTER_TIMEOUT_EN)
module axil_cmd_master #(
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timeout,
  axil_cmd_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;

  state_t      state, state_next;
  logic        accept, aw_done, w_done, b_fire, r_fire;
  logic        awvalid_q, wvalid_q, arvalid_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        unused_bits;

  assign cmd_ready = (state == IDLE);
  assign accept    = (state == IDLE) && cmd_valid;
  // A channel is done once its VALID has dropped or it handshakes this cycle.
  assign aw_done   = !awvalid_q || bus.M_AXI_AWREADY;
  assign w_done    = !wvalid_q || bus.M_AXI_WREADY;
  assign b_fire    = (state == WRESP) && bus.M_AXI_BVALID;
  assign r_fire    = (state == RDATA) && bus.M_AXI_RVALID;

  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_BREADY  = (state == WRESP);
  assign bus.M_AXI_RREADY  = (state == RDATA);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: write waits for both AW and W, read walks AR then R.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR : RADDR;
      WR:      if (aw_done && w_done) state_next = WRESP;
      WRESP:   if (bus.M_AXI_BVALID) state_next = IDLE;
      RADDR:   if (bus.M_AXI_ARREADY) state_next = RDATA;
      RDATA:   if (bus.M_AXI_RVALID) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered VALIDs: raised on accept, each dropped after its own handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      if (accept && cmd_write) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end else begin
        if (awvalid_q && bus.M_AXI_AWREADY) awvalid_q <= 1'b0;
        if (wvalid_q && bus.M_AXI_WREADY)   wvalid_q  <= 1'b0;
      end
      if (accept && !cmd_write)                 arvalid_q <= 1'b1;
      else if (arvalid_q && bus.M_AXI_ARREADY) arvalid_q <= 1'b0;
    end
  end

  // Command payload captured on accept and held stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Completion pulse plus result that holds until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= b_fire || r_fire;
      if (b_fire) begin
        rsp_err_q   <= bus.M_AXI_BRESP[1];
        rsp_rdata_q <= 32'd0;
      end else if (r_fire) begin
        rsp_err_q   <= bus.M_AXI_RRESP[1];
        rsp_rdata_q <= bus.M_AXI_RDATA;
      end
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_inc;
  logic        timeout_q;

  assign tmo_inc     = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  assign timeout     = timeout_q;
  assign unused_bits = bus.M_AXI_BRESP[0] ^ bus.M_AXI_RRESP[0];

  // Saturating busy-cycle counter; the flag is sticky until the next accept and never aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= 16'd0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt   <= 16'd0;
      timeout_q <= 1'b0;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_inc;
      if (tmo_inc >= TIMEOUT) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign unused_bits = bus.M_AXI_BRESP[0] ^ bus.M_AXI_RRESP[0] ^ (^TIMEOUT);
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - scoreboard bench for axil_cmd_master with a register-file slave model
module tb_axil_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic        cmd_ready, rsp_valid, rsp_err, timeout;
  logic [31:0] rsp_rdata;

  axil_cmd_master_if bus();

  axil_cmd_master #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timeout(timeout), .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0, miscompares = 0, cyc = 0, last_acc = 0;
  int          last_aw_len = 0, last_w_len = 0, last_ar_len = 0;
  int          fix_aw = 0, fix_w = 0, fix_b = 0, fix_ar = 0, fix_r = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_rdata = 32'd0;
  logic [1:0]  ovr_rresp = 2'd0;
  logic [31:0] ref_mem [16];
  logic [31:0] s_mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input int f);
    return (f < 0) ? int'($urandom_range(0, 3)) : f;
  endfunction

  // Reference: a 16-word register file; addr[12] marks an error slot (not written, reads 0),
  // addr[13] returns EXOKAY which is not an error.
  function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    e.acc = 0;
    e.lat = 0;
    e.err = a[12];
    if (w) begin
      e.rdata = 32'd0;
      if (!a[12]) ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~m) | (d & m);
    end else if (ovr_en) begin
      e.rdata = ovr_rdata;
      e.err   = ovr_rresp[1];
    end else begin
      e.rdata = a[12] ? 32'd0 : ref_mem[a[5:2]];
    end
    return e;
  endfunction

  // Slave model: decisions made at negedge so every handshake lands on the next posedge.
  initial begin
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_wt = 0, w_wt = 0, ar_wt = 0, b_wt = 0, r_wt = 0;
    int aw_run = 0, w_run = 0, ar_run = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    logic [31:0] c_awaddr = 0, c_wdata = 0, c_araddr = 0, aw_first = 0, w_first = 0, ar_first = 0;
    logic [3:0]  c_wstrb = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0;  bus.M_AXI_BRESP = 0;
    bus.M_AXI_RVALID = 0;  bus.M_AXI_RRESP = 0;  bus.M_AXI_RDATA = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID = 0;  bus.M_AXI_RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_run = 0; w_run = 0; ar_run = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (bus.M_AXI_AWVALID) begin
        if (aw_run == 0) aw_first = bus.M_AXI_AWADDR;
        else chk("awaddr_stable", bus.M_AXI_AWADDR, aw_first);
        aw_run++;
      end else if (aw_run != 0) begin last_aw_len = aw_run; aw_run = 0; end
      if (bus.M_AXI_WVALID) begin
        if (w_run == 0) w_first = bus.M_AXI_WDATA;
        else chk("wdata_stable", bus.M_AXI_WDATA, w_first);
        w_run++;
      end else if (w_run != 0) begin last_w_len = w_run; w_run = 0; end
      if (bus.M_AXI_ARVALID) begin
        if (ar_run == 0) ar_first = bus.M_AXI_ARADDR;
        else chk("araddr_stable", bus.M_AXI_ARADDR, ar_first);
        ar_run++;
      end else if (ar_run != 0) begin last_ar_len = ar_run; ar_run = 0; end
      if (bus.M_AXI_BREADY) chk("bready_after_aw_w", 32'(aw_got && w_got), 1);
      if (bus.M_AXI_RREADY) chk("rready_after_ar", 32'(ar_got), 1);

      if (b_fire) begin
        bus.M_AXI_BVALID = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end else if (aw_got && w_got) begin
        if (b_cnt == 0) b_wt = pick(fix_b);
        if (b_cnt >= b_wt) begin
          bus.M_AXI_BVALID = 1;
          bus.M_AXI_BRESP  = {c_awaddr[12], c_awaddr[13]};
        end
        b_cnt++;
        b_fire = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        if (b_fire && !c_awaddr[12])
          for (int k = 0; k < 4; k++)
            if (c_wstrb[k]) s_mem[c_awaddr[5:2]][8*k +: 8] = c_wdata[8*k +: 8];
      end

      if (r_fire) begin
        bus.M_AXI_RVALID = 0; r_fire = 0; ar_got = 0; r_cnt = 0;
      end else if (ar_got) begin
        if (r_cnt == 0) r_wt = pick(fix_r);
        if (r_cnt >= r_wt) begin
          bus.M_AXI_RVALID = 1;
          bus.M_AXI_RDATA  = ovr_en ? ovr_rdata : (c_araddr[12] ? 32'd0 : s_mem[c_araddr[5:2]]);
          bus.M_AXI_RRESP  = ovr_en ? ovr_rresp : {c_araddr[12], c_araddr[13]};
        end
        r_cnt++;
        r_fire = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
      end

      if (bus.M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt == 0) aw_wt = pick(fix_aw);
        aw_cnt++;
        if (aw_cnt > aw_wt) begin bus.M_AXI_AWREADY = 1; aw_got = 1; c_awaddr = bus.M_AXI_AWADDR; end
      end else begin bus.M_AXI_AWREADY = 0; aw_cnt = 0; end
      if (bus.M_AXI_WVALID && !w_got) begin
        if (w_cnt == 0) w_wt = pick(fix_w);
        w_cnt++;
        if (w_cnt > w_wt) begin
          bus.M_AXI_WREADY = 1; w_got = 1; c_wdata = bus.M_AXI_WDATA; c_wstrb = bus.M_AXI_WSTRB;
        end
      end else begin bus.M_AXI_WREADY = 0; w_cnt = 0; end
      if (bus.M_AXI_ARVALID && !ar_got) begin
        if (ar_cnt == 0) ar_wt = pick(fix_ar);
        ar_cnt++;
        if (ar_cnt > ar_wt) begin bus.M_AXI_ARREADY = 1; ar_got = 1; c_araddr = bus.M_AXI_ARADDR; end
      end else begin bus.M_AXI_ARREADY = 0; ar_cnt = 0; end
    end
  end

  // Monitor: every completion pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=0x%08h expected no response", rsp_rdata);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 3);
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit lat);
    exp_t e;
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles expected 1", n);
    end else begin
      e = model(w, a, d, s);
      e.acc = cyc; e.lat = lat;
      sb.push_back(e);
      last_acc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 0);
  endtask

  task automatic abort_with_reset();
    #2 rst = 1;
    #1;
    chk("rst_awvalid", 32'(bus.M_AXI_AWVALID), 0);
    chk("rst_wvalid", 32'(bus.M_AXI_WVALID), 0);
    chk("rst_arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("rst_bready", 32'(bus.M_AXI_BREADY), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ready_after_abort", 32'(cmd_ready), 1);
  endtask

  initial begin
    int a1, a2;
    logic [31:0] saved;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'd0; s_mem[i] = 32'd0; end
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_awvalid", 32'(bus.M_AXI_AWVALID), 0);
    chk("reset_wvalid", 32'(bus.M_AXI_WVALID), 0);
    chk("reset_arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("reset_rready", 32'(bus.M_AXI_RREADY), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_timeout", 32'(timeout), 0);
    chk("reset_wdata", bus.M_AXI_WDATA, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 1);

    last_aw_len = 0; last_w_len = 0;
    issue(1, 32'h000, 32'h2, 4'hF, 1);
    drain();
    chk("zw_aw_len", 32'(last_aw_len), 1);
    chk("zw_w_len", 32'(last_w_len), 1);

    last_aw_len = 0; last_w_len = 0; fix_w = 4;
    issue(1, 32'h004, $urandom, 4'hF, 0);
    drain();
    chk("slow_w_aw_len", 32'(last_aw_len), 1);
    chk("slow_w_w_len", 32'(last_w_len), 5);
    fix_w = 0;

    last_ar_len = 0; fix_ar = 2; ovr_en = 1; ovr_rdata = 32'hDEADBEEF; ovr_rresp = 2'b10;
    issue(0, 32'h010, 32'd0, 4'd0, 0);
    drain();
    chk("slow_ar_len", 32'(last_ar_len), 3);
    fix_ar = 0; ovr_en = 0;

    issue(0, 32'h000, 32'd0, 4'd0, 1);
    drain();

    issue(1, 32'h008, $urandom, 4'hF, 1); a1 = last_acc;
    issue(1, 32'h00C, $urandom, 4'h3, 1); a2 = last_acc;
    drain();
    chk("b2b_gap", 32'(a2 - a1), 3);

    fix_w = 20; saved = ref_mem[5];
    issue(1, 32'h014, $urandom, 4'hF, 0);
    cmd_valid = 0;
    chk("wvalid_waiting", 32'(bus.M_AXI_WVALID), 1);
    abort_with_reset();
    ref_mem[5] = saved; fix_w = 0;
    chk("post_abort_rsp_rdata", rsp_rdata, 0);

    fix_b = 1000; saved = ref_mem[6];
    issue(1, 32'h018, $urandom, 4'hF, 0);
    cmd_valid = 0;
    repeat (12) @(negedge clk);
    chk("stall_bready", 32'(bus.M_AXI_BREADY), 1);
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("stall_timeout", 32'(timeout), 1);
`else
    chk("stall_timeout", 32'(timeout), 0);
`endif
    abort_with_reset();
    ref_mem[6] = saved; fix_b = 0;

    fix_aw = -1; fix_w = -1; fix_b = -1; fix_ar = -1; fix_r = -1;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | (($urandom_range(0, 5) == 0) << 12) | ($urandom_range(0, 1) << 13);
      issue(bit'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      issue(0, 32'(i << 2), 32'd0, 4'd0, 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    miscompares++;
    $display("FAIL watchdog: got no end of test expected finish before 300000");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end
endmodule
